// File: rtl/muldiv_seq_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// muldiv_seq_if : command/result bundle for the iterative multiply/divide unit
// Revision: 1.0
// -----------------------------------------------------------------------------
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            flush;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, op1, op2, flush,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, op1, op2, flush,
    output busy, done, div_by_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// muldiv_seq : fixed-latency sequential mult/multu/div/divu (one bit per cycle)
// Revision: 1.0
// -----------------------------------------------------------------------------
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);
  localparam int            CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic                is_div_q, is_div_d;
  logic                neg_lo_q, neg_lo_d;
  logic                neg_hi_q, neg_hi_d;
  logic                dbz_pend_q, dbz_pend_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dbz_q, dbz_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;

  logic                signed_op;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_sh, div_diff;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   mul_next, div_next, fix_res;

  // acc holds {partial, multiplier} for mult and {remainder, quotient} for div
  always_comb begin
    signed_op = ~bus.op[0];
    mag1      = (signed_op && bus.op1[XLEN-1]) ? -bus.op1 : bus.op1;
    mag2      = (signed_op && bus.op2[XLEN-1]) ? -bus.op2 : bus.op2;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};

    // remainder < divisor keeps the difference inside +/-2^XLEN, so its MSB is the borrow
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_sh - {1'b0, b_q};
    div_ge    = ~div_diff[XLEN];
    div_rem   = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

    if (is_div_q) begin
      fix_res = {(neg_hi_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN]),
                 (neg_lo_q ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0])};
    end else begin
      fix_res = neg_lo_q ? -acc_q : acc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    b_d        = b_q;
    is_div_d   = is_div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    busy_d     = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);

    if (bus.flush && (state_q != IDLE)) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            is_div_d   = bus.op[1];
            neg_lo_d   = signed_op && (bus.op1[XLEN-1] ^ bus.op2[XLEN-1]);
            neg_hi_d   = signed_op && bus.op[1] && bus.op1[XLEN-1];
            acc_d      = {{XLEN{1'b0}}, mag1};
            b_d        = mag2;
            cnt_d      = '0;
            dbz_pend_d = bus.op[1] && (bus.op2 == {XLEN{1'b0}});
            if (bus.op[1] && (bus.op2 == {XLEN{1'b0}})) begin
              state_d = DONE;
            end else begin
              state_d = bus.op[1] ? DIV : MUL;
            end
          end
        end
        MUL: begin
          acc_d = mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
        DIV: begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
        FIX: begin
          acc_d   = fix_res;
          state_d = DONE;
        end
        DONE: begin
          done_d  = 1'b1;
          dbz_d   = dbz_pend_q;
          if (!dbz_pend_q) begin
            hi_d = acc_q[2*XLEN-1:XLEN];
            lo_d = acc_q[XLEN-1:0];
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      is_div_q   <= is_div_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_pend_q <= dbz_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_muldiv_seq : directed self-checking bench for muldiv_seq
// Revision: 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_muldiv_seq;
  localparam int XLEN  = 32;
  localparam int LAT   = XLEN + 2;
  localparam int LIMIT = 60;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();
  muldiv_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // operands are scrambled right after accept so a late change would corrupt the result
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op    = o;
    bus.op1   = a;
    bus.op2   = b;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    bus.op    = ~o;
    bus.op1   = ~a;
    bus.op2   = ~b;
  endtask

  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    do begin
      cyc();
      lat++;
      if (bus.busy && !bus.done) busy_cycles++;
    end while (!bus.done && lat < LIMIT);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_mult();
    int lat, bc;
    issue(2'd0, 32'hFFFFFFFE, 32'h00000003);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_c0: got %b want 0", bus.busy); end
    wait_done(lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("FAIL mult_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bc != LAT - 1) begin errors++; $display("FAIL mult_busy_cycles: got %0d want %0d", bc, LAT - 1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL mult_dbz: got %b want 0", bus.div_by_zero); end
    cyc();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b want 0", bus.done); end

    issue(2'd0, 32'h80000000, 32'h80000000);
    wait_done(lat, bc);
    checks++; if (bus.hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi: got %h want 40000000", bus.hi); end
    checks++; if (bus.lo !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo: got %h want 0", bus.lo); end
    cyc();
  endtask

  task automatic test_multu();
    int lat, bc;
    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("FAIL multu_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bus.hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 1", bus.lo); end
    cyc();
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL mult_m1_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'h1) begin errors++; $display("FAIL mult_m1_lo: got %h want 1", bus.lo); end
    cyc();
  endtask

  task automatic test_div();
    int lat, bc;
    issue(2'd2, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("FAIL div_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
    cyc();
    issue(2'd2, 32'h00000007, 32'hFFFFFFFE);
    wait_done(lat, bc);
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdiv_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'h00000001) begin errors++; $display("FAIL div_negdiv_hi: got %h want 1", bus.hi); end
    cyc();
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bc);
    checks++; if (bus.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h want 0", bus.hi); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_ovf_dbz: got %b want 0", bus.div_by_zero); end
    cyc();
    issue(2'd3, 32'hFFFFFFFF, 32'h00000010);
    wait_done(lat, bc);
    checks++; if (bus.lo !== 32'h0FFFFFFF) begin errors++; $display("FAIL divu_big_lo: got %h want 0fffffff", bus.lo); end
    checks++; if (bus.hi !== 32'h0000000F) begin errors++; $display("FAIL divu_big_hi: got %h want f", bus.hi); end
    cyc();
    issue(2'd3, 32'd100, 32'd7);
    wait_done(lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("FAIL divu_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 2", bus.hi); end
    cyc();
  endtask

  task automatic test_div_by_zero();
    issue(2'd3, 32'd5, 32'd0);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dbz_done_c0: got %b want 0", bus.done); end
    cyc();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL dbz_done_c1: got %b want 1", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_c1: got %b want 1", bus.div_by_zero); end
    checks++; if (bus.hi !== 32'd2) begin errors++; $display("FAIL dbz_hi_kept: got %h want 2", bus.hi); end
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL dbz_lo_kept: got %h want e", bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_busy: got %b want 0", bus.busy); end
    cyc();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dbz_done_c2: got %b want 0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dbz_flag_c2: got %b want 0", bus.div_by_zero); end
    issue(2'd2, 32'hFFFFFFFB, 32'd0);
    cyc();
    checks++; if (bus.div_by_zero !== 1'b1 || bus.done !== 1'b1) begin errors++; $display("FAIL dbz_signed: got done=%b dbz=%b want 1 1", bus.done, bus.div_by_zero); end
    cyc();
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first  = 0;
    issue(2'd3, 32'd1000, 32'd3);
    for (int n = 1; n <= 80; n++) begin
      if (n == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.op1   = 32'd5;
        bus.op2   = 32'd5;
      end else begin
        bus.start = 1'b0;
      end
      cyc();
      if (bus.done) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    bus.start = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_start_pulses: got %0d want 1", pulses); end
    checks++; if (first != LAT) begin errors++; $display("FAIL ignore_start_latency: got %0d want %0d", first, LAT); end
    checks++; if (bus.lo !== 32'd333) begin errors++; $display("FAIL ignore_start_lo: got %h want 14d", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL ignore_start_hi: got %h want 1", bus.hi); end
  endtask

  task automatic test_flush();
    int pulses = 0;
    issue(2'd0, 32'd12345, 32'd6789);
    for (int n = 1; n <= 9; n++) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_done: got %b want 0", bus.done); end
    for (int n = 0; n < 50; n++) begin
      cyc();
      if (bus.done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", pulses); end
    checks++; if (bus.hi !== 32'd1 || bus.lo !== 32'd333) begin errors++; $display("FAIL flush_hilo: got %h/%h want 1/14d", bus.hi, bus.lo); end

    // flush landing while the result is being retired
    issue(2'd1, 32'd2, 32'd3);
    for (int n = 1; n <= LAT - 1; n++) cyc();
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL flush_in_done_done: got %b want 0", bus.done); end
    checks++; if (bus.lo !== 32'd333) begin errors++; $display("FAIL flush_in_done_lo: got %h want 14d", bus.lo); end

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = 2'd1;
    cyc();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_beats_start: got busy=%b want 0", bus.busy); end
    cyc();
  endtask

  task automatic test_reset_mid_op();
    int pulses = 0;
    int lat, bc;
    issue(2'd2, 32'd1000, 32'd7);
    for (int n = 1; n <= 4; n++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    for (int n = 0; n < 50; n++) begin
      cyc();
      if (bus.done) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses want 0", pulses); end
    issue(2'd0, 32'd7, 32'hFFFFFFFD);
    wait_done(lat, bc);
    checks++; if (lat != LAT) begin errors++; $display("FAIL rst_after_latency: got %0d want %0d", lat, LAT); end
    checks++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL rst_after_result: got %h/%h want ffffffff/ffffffeb", bus.hi, bus.lo); end
    cyc();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 2'd0;
    bus.op1   = '0;
    bus.op2   = '0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_by_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
